// File: rtl/fsk_mod.sv
// fsk_mod: FSK modulator driving the DCO frequency code and the PA enable.
// A serial bit selects CENTER+DEV (1) or CENTER-DEV (0). The PA is held on
// around each packet, and dco_code returns to CENTER between packets.
// Build option FSK_MOD_SLEW_EN:
//   - defined:   the code slews linearly in STEP increments.
//   - undefined: hard FSK, where the code jumps straight to the target.
module fsk_mod #(
    parameter int CODE_W   = 8,
    parameter int CENTER   = 128,
    parameter int DEV      = 32,
    parameter int STEP     = 16,
    parameter int STEP_DIV = 4,
    parameter int PA_OFF   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tx,
    input  logic              tx_valid,
    output logic [CODE_W-1:0] dco_code,
    output logic              pa_en,
    output logic              code_settled,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        RAMP_DOWN = 2'd2,
        PA_HOLD   = 2'd3
    } state_t;

    localparam int HW = (PA_OFF > 1) ? $clog2(PA_OFF) : 1;
    localparam logic [CODE_W-1:0] CODE_CTR = CODE_W'(CENTER);
    localparam logic [CODE_W-1:0] CODE_HI  = CODE_W'(CENTER + DEV);
    localparam logic [CODE_W-1:0] CODE_LO  = CODE_W'(CENTER - DEV);
    localparam logic [HW-1:0]     HOLD_END = HW'(PA_OFF - 1);

    // Reject parameter sets that would wrap the code or break the step grid
    if ((STEP < 1) || ((DEV % STEP) != 0) || (STEP_DIV < 1) || (PA_OFF < 1) ||
        (CENTER - DEV < 0) || (CENTER + DEV >= (1 << CODE_W))) begin : g_bad_cfg
        $error("fsk_mod: invalid parameter set");
    end

    state_t            state_r;
    state_t            state_n_s;
    logic [HW-1:0]     hold_cnt_r;
    logic [HW-1:0]     hold_cnt_n_s;
    logic [CODE_W-1:0] target_s;
    logic [CODE_W-1:0] code_n_s;

    // Frequency target follows the live bit only while a packet is valid
    always_comb begin
        target_s = CODE_CTR;
        if (tx_valid) begin
            target_s = tx ? CODE_HI : CODE_LO;
        end else begin
            target_s = CODE_CTR;
        end
    end

`ifdef FSK_MOD_SLEW_EN
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_END = PW'(STEP_DIV - 1);
    localparam logic [CODE_W:0] STEP_WIDE = (CODE_W + 1)'(STEP);

    logic [PW-1:0]     presc_r;
    logic [PW-1:0]     presc_n_s;
    logic [CODE_W-1:0] tgt_r;
    logic              tgt_chg_s;
    logic              tick_s;

    // One STEP toward tgt, clamped at tgt; extra top bit keeps the sum from wrapping
    function automatic logic [CODE_W-1:0] slew_toward(input logic [CODE_W-1:0] cur,
                                                      input logic [CODE_W-1:0] tgt);
        logic [CODE_W:0] wide;
        wide = {1'b0, cur};
        if (cur < tgt) begin
            wide = {1'b0, cur} + STEP_WIDE;
            if (wide > {1'b0, tgt}) begin
                wide = {1'b0, tgt};
            end else begin
                wide = wide;
            end
        end else if (cur > tgt) begin
            if ({1'b0, cur} < ({1'b0, tgt} + STEP_WIDE)) begin
                wide = {1'b0, tgt};
            end else begin
                wide = {1'b0, cur} - STEP_WIDE;
            end
        end else begin
            wide = {1'b0, cur};
        end
        return wide[CODE_W-1:0];
    endfunction

    // Prescaler restarts on a new target so the first step lands STEP_DIV cycles later
    always_comb begin
        tgt_chg_s = (target_s != tgt_r);
        tick_s    = 1'b0;
        presc_n_s = presc_r;
        code_n_s  = dco_code;
        if (tgt_chg_s) begin
            presc_n_s = '0;
        end else if (presc_r == PRESC_END) begin
            tick_s    = 1'b1;
            presc_n_s = '0;
        end else begin
            presc_n_s = presc_r + PW'(1);
        end
        if (tick_s) begin
            code_n_s = slew_toward(dco_code, target_s);
        end else begin
            code_n_s = dco_code;
        end
    end

    // Slew timing state: prescaler and the target it is timing against
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
            tgt_r   <= CODE_CTR;
        end else if (!en) begin
            presc_r <= '0;
            tgt_r   <= CODE_CTR;
        end else begin
            presc_r <= presc_n_s;
            tgt_r   <= target_s;
        end
    end
`else
    // Hard FSK: the code takes the target on the next edge
    always_comb begin
        code_n_s = target_s;
    end
`endif

    // Packet sequencing: next state and PA hold-off count
    always_comb begin
        state_n_s    = state_r;
        hold_cnt_n_s = '0;
        case (state_r)
            IDLE: begin
                if (tx_valid) state_n_s = ACTIVE;
                else          state_n_s = IDLE;
            end
            ACTIVE: begin
                if (!tx_valid) state_n_s = RAMP_DOWN;
                else           state_n_s = ACTIVE;
            end
            RAMP_DOWN: begin
                if (tx_valid)                  state_n_s = ACTIVE;
                else if (code_n_s == CODE_CTR) state_n_s = PA_HOLD;
                else                           state_n_s = RAMP_DOWN;
            end
            PA_HOLD: begin
                if (tx_valid) begin
                    state_n_s = ACTIVE;
                end else if (hold_cnt_r == HOLD_END) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s    = PA_HOLD;
                    hold_cnt_n_s = hold_cnt_r + HW'(1);
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State, code and status outputs, all registered from next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            hold_cnt_r   <= '0;
            dco_code     <= CODE_CTR;
            pa_en        <= 1'b0;
            code_settled <= 1'b0;
            busy         <= 1'b0;
        end else if (!en) begin
            state_r      <= IDLE;
            hold_cnt_r   <= '0;
            dco_code     <= CODE_CTR;
            pa_en        <= 1'b0;
            code_settled <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            hold_cnt_r   <= hold_cnt_n_s;
            dco_code     <= code_n_s;
            pa_en        <= (state_n_s != IDLE);
            code_settled <= (state_n_s == ACTIVE) && (code_n_s == target_s);
            busy         <= (state_n_s != IDLE);
        end
    end

endmodule

// File: tb/tb_fsk_mod.sv
// Directed, table-driven bench for fsk_mod with default parameters.
// Each table record is one clock cycle: the inputs to drive and the expected outputs.
// Expectations cover both FSK_MOD_SLEW_EN builds.
module tb_fsk_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tx;
    logic       tx_valid;
    logic [7:0] dco_code;
    logic       pa_en;
    logic       code_settled;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic       v;
        logic       tx;
        logic [7:0] code;
        logic       pa;
        logic       set;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    fsk_mod dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .tx           (tx),
        .tx_valid     (tx_valid),
        .dco_code     (dco_code),
        .pa_en        (pa_en),
        .code_settled (code_settled),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic push(input logic e, input logic v, input logic t, input logic [7:0] c,
                        input logic p, input logic s, input logic b, input int reps);
        vec_t r;
        r.en = e; r.v = v; r.tx = t; r.code = c; r.pa = p; r.set = s; r.busy = b;
        for (int i = 0; i < reps; i++) vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] c, input logic p,
                             input logic s, input logic b);
        check({tag, ".code"}, dco_code, c);
        check({tag, ".pa_en"}, {7'd0, pa_en}, {7'd0, p});
        check({tag, ".settled"}, {7'd0, code_settled}, {7'd0, s});
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tx = 1'b0; tx_valid = 1'b0;

        // idle with en high
        push(1'b1, 1'b0, 1'b0, 8'd128, 1'b0, 1'b0, 1'b0, 100);
`ifdef FSK_MOD_SLEW_EN
        // packet start with tx=1
        push(1'b1, 1'b1, 1'b1, 8'd128, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b1, 8'd144, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b1, 8'd160, 1'b1, 1'b1, 1'b1, 4);
        // 1 -> 0 full swing
        push(1'b1, 1'b1, 1'b0, 8'd160, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd144, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd128, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd112, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd96,  1'b1, 1'b1, 1'b1, 4);
        // tx_valid falls (tx=1 must be ignored), ramp down and PA hold
        push(1'b1, 1'b0, 1'b1, 8'd96,  1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b0, 1'b1, 8'd112, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b0, 1'b1, 8'd128, 1'b1, 1'b0, 1'b1, 8);
        push(1'b1, 1'b0, 1'b1, 8'd128, 1'b0, 1'b0, 1'b0, 4);
        // reassert during RAMP_DOWN at code 112
        push(1'b1, 1'b1, 1'b0, 8'd128, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd112, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd96,  1'b1, 1'b1, 1'b1, 2);
        push(1'b1, 1'b0, 1'b0, 8'd96,  1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b0, 1'b0, 8'd112, 1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 1'b1, 1'b1, 8'd112, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b1, 8'd128, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b1, 8'd144, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b1, 8'd160, 1'b1, 1'b1, 1'b1, 2);
        // en low mid-packet; tx_valid with en low is ignored
        push(1'b0, 1'b1, 1'b1, 8'd128, 1'b0, 1'b0, 1'b0, 3);
        // reassert during PA_HOLD
        push(1'b1, 1'b1, 1'b0, 8'd128, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd112, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd96,  1'b1, 1'b1, 1'b1, 2);
        push(1'b1, 1'b0, 1'b0, 8'd96,  1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b0, 1'b0, 8'd112, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b0, 1'b0, 8'd128, 1'b1, 1'b0, 1'b1, 3);
        push(1'b1, 1'b1, 1'b0, 8'd128, 1'b1, 1'b0, 1'b1, 4);
        push(1'b1, 1'b1, 1'b0, 8'd112, 1'b1, 1'b0, 1'b1, 1);
`else
        // packet start with tx=1: code jumps straight to 160
        push(1'b1, 1'b1, 1'b1, 8'd160, 1'b1, 1'b1, 1'b1, 4);
        // 1 -> 0 jumps 160 -> 96 next cycle
        push(1'b1, 1'b1, 1'b0, 8'd96,  1'b1, 1'b1, 1'b1, 4);
        // tx_valid falls: 1-cycle RAMP_DOWN then 8-cycle PA hold
        push(1'b1, 1'b0, 1'b1, 8'd128, 1'b1, 1'b0, 1'b1, 9);
        push(1'b1, 1'b0, 1'b1, 8'd128, 1'b0, 1'b0, 1'b0, 4);
        // reassert during RAMP_DOWN
        push(1'b1, 1'b1, 1'b0, 8'd96,  1'b1, 1'b1, 1'b1, 2);
        push(1'b1, 1'b0, 1'b0, 8'd128, 1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 1'b1, 1'b1, 8'd160, 1'b1, 1'b1, 1'b1, 3);
        // en low mid-packet; tx_valid with en low is ignored
        push(1'b0, 1'b1, 1'b1, 8'd128, 1'b0, 1'b0, 1'b0, 3);
        // reassert during PA_HOLD
        push(1'b1, 1'b1, 1'b0, 8'd96,  1'b1, 1'b1, 1'b1, 2);
        push(1'b1, 1'b0, 1'b0, 8'd128, 1'b1, 1'b0, 1'b1, 3);
        push(1'b1, 1'b1, 1'b0, 8'd96,  1'b1, 1'b1, 1'b1, 2);
`endif
        push(1'b0, 1'b0, 1'b0, 8'd128, 1'b0, 1'b0, 1'b0, 1);

        // reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'd128, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en       = vecs[i].en;
            tx_valid = vecs[i].v;
            tx       = vecs[i].tx;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].code, vecs[i].pa,
                      vecs[i].set, vecs[i].busy);
        end

        // asynchronous reset mid-packet
        en = 1'b1; tx_valid = 1'b1; tx = 1'b1;
`ifdef FSK_MOD_SLEW_EN
        repeat (9) tick();
`else
        tick();
`endif
        check_all("pre_rst", 8'd160, 1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 8'd128, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tx_valid = 1'b0;
        tick();
        check_all("post_rst", 8'd128, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
